irq_grant_dispatcher: RTL and testbench
=======================================

// Module: irq_grant_dispatcher
// PURPOSE
//  Sequential back end for the 27-channel combinational priority resolver (3 groups x 9 channels).
//  - Front side: latches raw interrupt requests into a pending register and drives that register to the resolver.
//  - Resolver side: takes the resolver's group/channel result and presents it to the CPU with a valid/ready handshake.
//  - Acknowledge: on completion, pulses a one-hot acknowledge to the winning source and clears its pending bit.
// PARAMETERS
//  NGRP   3   number of request groups (A,B,C)
//  NCHAN  9   channels per group; the channel index fits in 4 bits
//  SETTLE 1   cycles waited after pending changes before sampling the resolver (1..3)
// PORTS
//  clk          in   1          clock; all state updates on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  en           in   1          dispatch enable; 0 holds FSM in IDLE, pending still accumulates
//  irq_req      in   27         level requests; bit g*9+c = group g, channel c
//  pend         out  27         registered pending vector, drives resolver inputs
//  res_grp      in   3          resolver group-active flags, one-hot for the winning group, 0 = none
//  res_chan     in   4          resolver winning channel within group, 0..8
//  irq_valid    out  1          CPU vector valid
//  irq_id       out  6          {grp[1:0], chan[3:0]} of the presented interrupt
//  irq_ready    in   1          CPU accepts the vector
//  irq_ack      out  27         one-cycle one-hot acknowledge to the source
//  err          out  1          sticky illegal-resolver-result flag; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): pend=0, irq_valid=0, irq_id=0, irq_ack=0, err=0, FSM=IDLE, settle counter=0.
//  Pending: each cycle pend <= (pend | irq_req) & ~clr.
//   - clr is nonzero only in the ACK state.
//   - Clear beats set for the acked bit in the same cycle.
//   - A still-asserted level re-pends that bit on the next cycle; sources must drop the request on irq_ack.
//  FSM:
//   - IDLE: if en & |pend, load cnt=SETTLE and go to WAIT; else stay.
//   - WAIT: decrement cnt. At cnt==0, sample res_grp/res_chan:
//       - res_grp==0: back to IDLE (race; pending was cleared).
//       - res_grp not one-hot, or res_chan>8: set err, back to IDLE, no vector issued.
//       - res_grp one-hot and res_chan<=8 but the target pend bit is 0: set err, back to IDLE.
//       - otherwise: latch irq_id = {onehot2bin(res_grp), res_chan}, go to PRESENT.
//   - PRESENT: irq_valid=1 with irq_id stable.
//       - Hold until irq_ready=1; the transfer completes in that cycle.
//       - Then go to ACK with irq_valid=0 on the next cycle.
//       - Deasserting en here does NOT abort the transfer.
//   - ACK: for exactly one cycle, irq_ack[id] = 1 and clr = same bit; then go to IDLE.
//  Latency: request rise to irq_valid = 3+SETTLE cycles minimum (latch, IDLE, WAIT..., PRESENT).
//  Back-to-back: IDLE is re-entered for at least one cycle between vectors, so at most one vector per 4+SETTLE cycles.
//  Group encoding: group A = 0, B = 1, C = 2; irq_id[5:4] = 3 never occurs.
//  New requests during WAIT/PRESENT only set pend bits. The presented vector is never replaced mid-handshake.
//  Async reset mid-operation: all outputs drop immediately, including an in-flight irq_valid. The CPU discards the partial vector.
//  All outputs are registered; there is no combinational path from inputs to outputs.
// TESTING
//  T1 reset: rst_n=0 asynchronously mid-PRESENT -> irq_valid=0, pend=0 the same instant; err=0.
//  T2 single request:
//     - Stimulus: irq_req[13]=1 one cycle, resolver model returns grp=3'b010, chan=4; irq_ready=1.
//     - Expected: irq_id=6'b01_0100, irq_ack[13] pulses once, pend[13]=0 afterwards.
//  T3 backpressure: irq_ready held 0 for 10 cycles -> irq_valid and irq_id stay constant; irq_ack=0 throughout.
//  T4 priority drain:
//     - Stimulus: irq_req bits 0, 9, 26 set together; resolver model is priority-ordered.
//     - Expected: three vectors in order id 0x00, 0x10, 0x28; each matching irq_ack fires once.
//  T5 illegal resolver:
//     - Stimulus: res_grp=3'b011 or res_chan=4'd9 while pend!=0.
//     - Expected: err=1 and sticky, no irq_valid; a later legal result still dispatches.
//  T6 set/clear collision: irq_req[5] held high through its ACK -> pend[5]=0 for the ACK cycle, 1 the next cycle, second vector issued.

Source files
------------

// File: rtl/irq_grant_dispatcher.sv
// Purpose: sequential back end for a 27-channel (3 groups x 9 channels) combinational priority resolver.
// Latency: request to irq_valid is 3+SETTLE cycles minimum; IDLE is revisited between vectors (4+SETTLE per vector).
// Backpressure: irq_valid/irq_id hold in PRESENT until irq_ready; new requests only accumulate in pend meanwhile.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  dispatch enable (pending accumulates regardless)
//   irq_req[26:0]       level requests, bit g*9+c = group g channel c
//   pend[26:0]          registered pending vector, feeds the resolver
//   res_grp[2:0]        resolver one-hot winning group (0 = none)
//   res_chan[3:0]       resolver winning channel within the group
//   irq_valid, irq_id   CPU vector {grp[1:0], chan[3:0]}, handshake with irq_ready
//   irq_ack[26:0]       one-cycle one-hot acknowledge to the winning source
//   err                 sticky illegal-resolver-result flag
module irq_grant_dispatcher #(
  parameter int NGRP   = 3,
  parameter int NCHAN  = 9,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NGRP*NCHAN-1:0] irq_req,
  output logic [NGRP*NCHAN-1:0] pend,
  input  logic [NGRP-1:0]       res_grp,
  input  logic [3:0]            res_chan,
  output logic                  irq_valid,
  output logic [5:0]            irq_id,
  input  logic                  irq_ready,
  output logic [NGRP*NCHAN-1:0] irq_ack,
  output logic                  err
);

  localparam int NW = NGRP * NCHAN;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    cnt;

  // Decoded resolver result and control strobes.
  logic          sample;
  logic [1:0]    grp_bin;
  logic          grp_onehot;
  logic          chan_ok;
  logic [5:0]    tgt_idx;
  logic [NW-1:0] pend_sh;
  logic          vec_ok;
  logic          set_err;
  logic [4:0]    ack_idx;
  logic [NW-1:0] ack_vec;
  logic [NW-1:0] clr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (en && (|pend)) state_nxt = S_WAIT;
      S_WAIT:    if (cnt == 2'd0) state_nxt = vec_ok ? S_PRESENT : S_IDLE;
      S_PRESENT: if (irq_ready) state_nxt = S_ACK;
      S_ACK:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    sample  = (state == S_WAIT) && (cnt == 2'd0);

    grp_bin = 2'd0;
    for (int g = 0; g < NGRP; g++) begin
      if (res_grp[g]) grp_bin = grp_bin | 2'(g);
    end
    grp_onehot = (res_grp != '0) && ((res_grp & (res_grp - 1'b1)) == '0);
    chan_ok    = (res_chan < 4'(NCHAN));

    // The resolver's claim must name a bit that is actually pending,
    // otherwise it is reporting a stale or corrupted winner.
    tgt_idx = {4'd0, grp_bin} * 6'(NCHAN) + {2'd0, res_chan};
    pend_sh = pend >> tgt_idx;
    vec_ok  = grp_onehot && chan_ok && pend_sh[0];

    // res_grp==0 is a benign race (pending vanished), not an error.
    set_err = sample && (res_grp != '0) && !vec_ok;

    ack_idx = {3'd0, irq_id[5:4]} * 5'(NCHAN) + {1'b0, irq_id[3:0]};
    ack_vec = NW'(1) << ack_idx;

    // Only the ACK state clears; irq_ack is registered and equals the bit to clear.
    clr = (state == S_ACK) ? irq_ack : '0;
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      cnt       <= 2'd0;
      irq_valid <= 1'b0;
      irq_id    <= 6'd0;
      irq_ack   <= '0;
      err       <= 1'b0;
    end else begin
      // Clear beats set for the acked bit; a held level re-pends a cycle later.
      pend <= (pend | irq_req) & ~clr;

      if ((state == S_IDLE) && (state_nxt == S_WAIT)) begin
        cnt <= 2'(SETTLE);
      end else if ((state == S_WAIT) && (cnt != 2'd0)) begin
        cnt <= cnt - 2'd1;
      end

      irq_valid <= (state_nxt == S_PRESENT);

      if (sample && vec_ok) begin
        irq_id <= {grp_bin, res_chan};
      end

      irq_ack <= ((state == S_PRESENT) && (state_nxt == S_ACK)) ? ack_vec : '0;

      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_irq_grant_dispatcher.sv
module tb_irq_grant_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [26:0] irq_req;
  logic [26:0] pend;
  logic [2:0]  res_grp;
  logic [3:0]  res_chan;
  logic        irq_valid;
  logic [5:0]  irq_id;
  logic        irq_ready;
  logic [26:0] irq_ack;
  logic        err;

  // Resolver model controls
  logic        ovr_en;
  logic [2:0]  ovr_grp;
  logic [3:0]  ovr_chan;

  int total;
  int bad;

  irq_grant_dispatcher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .irq_req   (irq_req),
    .pend      (pend),
    .res_grp   (res_grp),
    .res_chan  (res_chan),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ready (irq_ready),
    .irq_ack   (irq_ack),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Priority resolver model: lowest pending index wins, unless overridden.
  always_comb begin
    res_grp  = 3'd0;
    res_chan = 4'd0;
    if (ovr_en) begin
      res_grp  = ovr_grp;
      res_chan = ovr_chan;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (pend[i]) begin
          res_grp  = 3'b001 << (i / 9);
          res_chan = 4'(i % 9);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int maxc, output int n);
    n = 0;
    while (!irq_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(irq_valid), 64'd1);
  endtask

  task automatic do_rst();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [2:0] t5_grp  [4];
  logic [3:0] t5_chan [4];
  logic       t5_err  [4];

  initial begin
    int  n;
    logic seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en = 1'b0;
    irq_req = '0;
    irq_ready = 1'b0;
    ovr_en = 1'b0;
    ovr_grp = 3'd0;
    ovr_chan = 4'd0;
    t5_grp  = '{3'b000, 3'b011, 3'b001, 3'b001};
    t5_chan = '{4'd0,   4'd0,   4'd9,   4'd5};
    t5_err  = '{1'b0,   1'b1,   1'b1,   1'b1};

    // Reset state
    step(); step();
    chk("rst_pend",  64'(pend), 64'd0);
    chk("rst_valid", 64'(irq_valid), 64'd0);
    chk("rst_id",    64'(irq_id), 64'd0);
    chk("rst_ack",   64'(irq_ack), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    rst_n = 1'b1;
    step();

    // T2 single request, bit 13 = group B channel 4
    en = 1'b1;
    irq_ready = 1'b1;
    irq_req = 27'd1 << 13;
    step();
    irq_req = '0;
    chk("t2_pend_set", 64'(pend), 64'(27'd1 << 13));
    wait_valid("t2_valid", 10, n);
    chk("t2_latency", 64'(n), 64'd3);
    chk("t2_id", 64'(irq_id), 64'h14);
    chk("t2_no_ack_yet", 64'(irq_ack), 64'd0);
    step();
    chk("t2_ack", 64'(irq_ack), 64'(27'd1 << 13));
    chk("t2_valid_drop", 64'(irq_valid), 64'd0);
    step();
    chk("t2_ack_once", 64'(irq_ack), 64'd0);
    chk("t2_pend_clr", 64'(pend), 64'd0);

    // T3 backpressure, bit 20 = group C channel 2; en drop and new request mid-handshake
    irq_ready = 1'b0;
    irq_req = 27'd1 << 20;
    step();
    irq_req = '0;
    wait_valid("t3_valid", 10, n);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold", 64'({irq_valid, irq_id, irq_ack}), 64'({1'b1, 6'h22, 27'd0}));
      if (i == 0) begin
        irq_req = 27'd1;
        en = 1'b0;
      end
      if (i == 1) irq_req = '0;
      step();
    end
    irq_ready = 1'b1;
    step();
    chk("t3_ack", 64'(irq_ack), 64'(27'd1 << 20));
    chk("t3_valid_drop", 64'(irq_valid), 64'd0);
    step();
    chk("t3_pend_left", 64'(pend), 64'd1);
    seen = 1'b0;
    repeat (4) begin
      step();
      seen = seen | irq_valid;
    end
    chk("t3_en_gate", 64'(seen), 64'd0);
    en = 1'b1;
    wait_valid("t3_valid2", 10, n);
    chk("t3_id2", 64'(irq_id), 64'h00);
    step();
    chk("t3_ack2", 64'(irq_ack), 64'd1);
    step();

    // T4 priority drain
    irq_req = (27'd1 << 0) | (27'd1 << 9) | (27'd1 << 26);
    step();
    irq_req = '0;
    for (int k = 0; k < 3; k++) begin
      logic [5:0]  exp_id;
      logic [26:0] exp_ack;
      exp_id  = (k == 0) ? 6'h00 : (k == 1) ? 6'h10 : 6'h28;
      exp_ack = (k == 0) ? 27'd1 : (k == 1) ? (27'd1 << 9) : (27'd1 << 26);
      wait_valid("t4_valid", 12, n);
      if (k > 0) chk("t4_spacing", 64'(n), 64'd4);
      chk("t4_id", 64'(irq_id), 64'(exp_id));
      step();
      chk("t4_ack", 64'(irq_ack), 64'(exp_ack));
    end
    step();
    chk("t4_pend_empty", 64'(pend), 64'd0);
    chk("t4_ack_idle", 64'(irq_ack), 64'd0);

    // T5 illegal resolver results (first entry is the benign none-found race)
    for (int c = 0; c < 4; c++) begin
      ovr_en = 1'b1;
      ovr_grp = t5_grp[c];
      ovr_chan = t5_chan[c];
      do_rst();
      irq_req = 27'd1 << 3;
      step();
      irq_req = '0;
      seen = 1'b0;
      repeat (10) begin
        step();
        seen = seen | irq_valid;
      end
      chk("t5_no_valid", 64'(seen), 64'd0);
      chk("t5_err", 64'(err), 64'(t5_err[c]));
      chk("t5_pend_kept", 64'(pend), 64'(27'd1 << 3));
    end
    ovr_en = 1'b0;
    wait_valid("t5_legal_valid", 8, n);
    chk("t5_legal_id", 64'(irq_id), 64'h03);
    chk("t5_err_sticky", 64'(err), 64'd1);
    step();
    chk("t5_legal_ack", 64'(irq_ack), 64'(27'd1 << 3));
    step();

    // T6 set/clear collision with a held level on bit 5
    irq_req = 27'd1 << 5;
    wait_valid("t6_valid", 10, n);
    chk("t6_id", 64'(irq_id), 64'h05);
    step();
    chk("t6_ack", 64'(irq_ack), 64'(27'd1 << 5));
    step();
    chk("t6_pend_cleared", 64'(pend[5]), 64'd0);
    step();
    chk("t6_pend_repend", 64'(pend[5]), 64'd1);
    wait_valid("t6_valid2", 10, n);
    chk("t6_id2", 64'(irq_id), 64'h05);
    irq_req = '0;
    step();
    chk("t6_ack2", 64'(irq_ack), 64'(27'd1 << 5));
    step(); step();
    chk("t6_pend_final", 64'(pend), 64'd0);
    chk("t6_err_still", 64'(err), 64'd1);

    // T1 async reset mid-PRESENT
    irq_ready = 1'b0;
    irq_req = 27'd1 << 13;
    step();
    irq_req = '0;
    wait_valid("t1_valid", 10, n);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 64'(irq_valid), 64'd0);
    chk("t1_pend",  64'(pend), 64'd0);
    chk("t1_err",   64'(err), 64'd0);
    chk("t1_id",    64'(irq_id), 64'd0);
    chk("t1_ack",   64'(irq_ack), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
